// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and port indices.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        XFER = 2'd2,
        ACK  = 2'd3
    } state_t;

    // Port index: 0 = fetch port, 1 = data port.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the port
// that was not granted last wins.
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant
);

    // Pick the winner index from the current requests and the last grant.
    always_comb begin
        grant = PORT0;
        if (req0 && req1) grant = ~last;
        else if (req1)    grant = PORT1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported Memory with a split data bus.
// Each access walks IDLE -> ADDR -> XFER -> ACK; all outputs are registered
// and depend only on state and the request latched in IDLE.
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [WORD_WIDTH-1:0]    wdata0,
    input  logic [WORD_WIDTH-1:0]    wdata1,
    output logic                     ack0,
    output logic                     ack1,
    output logic [WORD_WIDTH-1:0]    rdata,
    output logic                     mem_ain,
    output logic                     mem_din,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     mem_dout,
    output logic [ADDRESS_WIDTH-1:0] mem_abus,
    output logic [WORD_WIDTH-1:0]    dbus_o,
    output logic                     dbus_oe,
    input  logic [WORD_WIDTH-1:0]    dbus_i
);

    state_t state;
    logic   last;      // port granted most recently
    logic   lat_port;  // owner of the access in flight
    logic   lat_we;    // direction of the access in flight
    logic   grant;

    logic                     sel_we;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [WORD_WIDTH-1:0]    sel_wdata;

    rr_arb2 u_arb (
        .req0  (req0),
        .req1  (req1),
        .last  (last),
        .grant (grant)
    );

    // Route the winning port's request fields; only consumed in IDLE.
    always_comb begin
        sel_we    = (grant == PORT1) ? we1    : we0;
        sel_addr  = (grant == PORT1) ? addr1  : addr0;
        sel_wdata = (grant == PORT1) ? wdata1 : wdata0;
    end

    // Access FSM. Outputs are loaded for the state being entered, so every
    // strobe is a flop output and cannot glitch on req/addr/wdata. The
    // address and write data registers double as the request latch, which
    // keeps the in-flight access immune to later input changes.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            last      <= PORT1;
            lat_port  <= PORT0;
            lat_we    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            mem_ain   <= 1'b0;
            mem_din   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_dout  <= 1'b0;
            mem_abus  <= '0;
            dbus_o    <= '0;
            dbus_oe   <= 1'b0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_ain   <= 1'b0;
            mem_din   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_dout  <= 1'b0;
            mem_abus  <= '0;
            dbus_o    <= '0;
            dbus_oe   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        lat_port <= grant;
                        lat_we   <= sel_we;
                        mem_ain  <= 1'b1;
                        mem_abus <= sel_addr;
                        if (sel_we) begin
                            mem_din <= 1'b1;
                            dbus_oe <= 1'b1;
                            dbus_o  <= sel_wdata;
                        end
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (lat_we) begin
                        mem_write <= 1'b1;
                    end else begin
                        mem_read <= 1'b1;
                        mem_dout <= 1'b1;
                    end
                    state <= XFER;
                end
                XFER: begin
                    if (!lat_we) rdata <= dbus_i;
                    ack0  <= (lat_port == PORT0);
                    ack1  <= (lat_port == PORT1);
                    state <= ACK;
                end
                ACK: begin
                    last  <= lat_port;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural Memory and an
// ack scoreboard (port, ack cycle, read data).
module tb_mem_arbiter;
    import mem_ctrl_pkg::*;

    localparam int WW = 8;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [WW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, mem_ain, mem_din, mem_read, mem_write, mem_dout, dbus_oe;
    logic [WW-1:0] rdata, dbus_o, dbus_i;
    logic [AW-1:0] mem_abus;

    mem_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .mem_ain(mem_ain), .mem_din(mem_din), .mem_read(mem_read),
        .mem_write(mem_write), .mem_dout(mem_dout), .mem_abus(mem_abus),
        .dbus_o(dbus_o), .dbus_oe(dbus_oe), .dbus_i(dbus_i)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Memory: address and data registers loaded by mem_ain / mem_din,
    // array written on mem_write, drives the bus while mem_dout is high.
    logic [WW-1:0] mem [32] = '{1: 8'h11, 2: 8'h22, default: 8'h00};
    logic [AW-1:0] areg = '0;
    logic [WW-1:0] dreg = '0;
    always @(posedge CLK) begin
        if (mem_ain)   areg <= mem_abus;
        if (mem_din)   dreg <= dbus_o;
        if (mem_write) mem[areg] <= dreg;
    end
    assign dbus_i = mem_dout ? mem[areg] : '0;

    int passes = 0;
    int total  = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Bus-level invariants checked in every cycle.
    always @(negedge CLK) begin
        check("rd_wr_excl", {31'd0, mem_read & mem_write}, 0);
        check("oe_dout_excl", {31'd0, dbus_oe & mem_dout}, 0);
        check("ack_excl", {31'd0, ack0 & ack1}, 0);
    end

    typedef struct {
        logic          port;
        logic          rd_op;
        logic [WW-1:0] rd;
        int            at;
    } exp_t;
    exp_t sb[$];
    logic [WW-1:0] last_rd = '0;

    task automatic issue(logic p, logic we, logic [AW-1:0] a, logic [WW-1:0] d,
                         logic [WW-1:0] rd, int at, bit push);
        if (p == PORT0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        else            begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        if (push) sb.push_back('{p, !we, rd, at});
    endtask

    // Pop one scoreboard entry per ack; optionally release the acked req.
    task automatic wait_acks(int n, bit drop);
        int   got = 0;
        int   budget = 0;
        exp_t e;
        while (got < n && budget < 40) begin
            @(negedge CLK);
            budget++;
            if (ack0 || ack1) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("ack_port", {31'd0, ack1}, {31'd0, e.port});
                    check("ack_cycle", cyc, e.at);
                    if (e.rd_op) begin
                        check("rdata", {24'd0, rdata}, {24'd0, e.rd});
                        last_rd = e.rd;
                    end else begin
                        check("rdata_hold", {24'd0, rdata}, {24'd0, last_rd});
                    end
                end
                got++;
                if (drop) begin
                    if (ack0) req0 = 0;
                    if (ack1) req1 = 0;
                end
            end
        end
        if (got < n) check("ack_timeout", got, n);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge CLK);
        check("rst_strobes", {24'd0, ack0, ack1, mem_ain, mem_din, mem_read,
                              mem_write, mem_dout, dbus_oe}, 0);
        check("rst_abus", {27'd0, mem_abus}, 0);
        check("rst_dbus_o", {24'd0, dbus_o}, 0);
        check("rst_rdata", {24'd0, rdata}, 0);
        check("rst_state", {30'd0, dut.state}, {30'd0, IDLE});

        // Simultaneous reads right after reset: port 0 first, port 1 four later.
        RSTn = 1;
        issue(PORT0, 0, 5'd1, 8'h00, 8'h11, cyc + 3, 1);
        issue(PORT1, 0, 5'd2, 8'h00, 8'h22, cyc + 7, 1);
        wait_acks(2, 1);

        // Port 1 write 0xA5 to 5, with ADDR/XFER strobe checks, then read back.
        @(negedge CLK);
        issue(PORT1, 1, 5'd5, 8'hA5, 8'h00, cyc + 3, 1);
        @(negedge CLK);
        check("addr_w_strobes", {29'd0, mem_ain, mem_din, dbus_oe}, 32'h7);
        check("addr_w_abus", {27'd0, mem_abus}, 5);
        check("addr_w_dbus", {24'd0, dbus_o}, 32'hA5);
        @(negedge CLK);
        check("xfer_w_strobes", {27'd0, mem_write, mem_read, mem_dout, mem_ain, dbus_oe}, 32'h10);
        check("xfer_w_abus", {27'd0, mem_abus}, 0);
        wait_acks(1, 1);
        check("mem5", {24'd0, mem[5]}, 32'hA5);
        @(negedge CLK);
        issue(PORT1, 0, 5'd5, 8'h00, 8'hA5, cyc + 3, 1);
        @(negedge CLK);
        check("addr_r_strobes", {29'd0, mem_ain, mem_din, dbus_oe}, 32'h4);
        @(negedge CLK);
        check("xfer_r_strobes", {29'd0, mem_read, mem_dout, mem_write}, 32'h6);
        wait_acks(1, 1);

        // Both requests held: grants alternate 0,1,0,1 at 4-cycle spacing.
        @(negedge CLK);
        issue(PORT0, 0, 5'd1, 8'h00, 8'h11, cyc + 3, 1);
        issue(PORT1, 0, 5'd2, 8'h00, 8'h22, cyc + 7, 1);
        issue(PORT0, 0, 5'd1, 8'h00, 8'h11, cyc + 11, 1);
        issue(PORT1, 0, 5'd2, 8'h00, 8'h22, cyc + 15, 1);
        wait_acks(4, 0);
        req0 = 0;
        req1 = 0;

        // Port 0 write whose req and fields change during ADDR.
        @(negedge CLK);
        issue(PORT0, 1, 5'd3, 8'h3C, 8'h00, cyc + 3, 1);
        @(negedge CLK);
        req0 = 0; we0 = 0; addr0 = 5'd9; wdata0 = 8'h00;
        wait_acks(1, 1);
        check("mem3", {24'd0, mem[3]}, 32'h3C);
        check("mem9_untouched", {24'd0, mem[9]}, 0);

        // Reset pulsed during XFER of a write: abort with no ack, no write.
        @(negedge CLK);
        issue(PORT0, 1, 5'd7, 8'hFF, 8'h00, 0, 0);
        repeat (2) @(negedge CLK);
        check("pre_abort_write", {31'd0, mem_write}, 1);
        RSTn = 0;
        #1;
        check("abort_strobes", {24'd0, ack0, ack1, mem_ain, mem_din, mem_read,
                                mem_write, mem_dout, dbus_oe}, 0);
        check("abort_state", {30'd0, dut.state}, {30'd0, IDLE});
        @(negedge CLK);
        check("abort_no_ack", {30'd0, ack0, ack1}, 0);
        check("mem7_kept", {24'd0, mem[7]}, 0);
        req0 = 0;
        RSTn = 1;
        // Request presented as reset releases is taken on the next edge.
        issue(PORT1, 0, 5'd5, 8'h00, 8'hA5, cyc + 3, 1);
        wait_acks(1, 1);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WORD_WIDTH, 8, data word width; SHALL match the attached Memory instance.
REQ-002 Parameter: ADDRESS_WIDTH, 5, address width; SHALL match the attached Memory instance.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 RSTn  in  1  asynchronous active-low reset.
REQ-006 req0, req1  in  1 each  access request from port 0 (fetch) and port 1 (data); held until ack.
REQ-007 we0, we1  in  1 each  1 = write, 0 = read; valid while req is high.
REQ-008 addr0, addr1  in  ADDRESS_WIDTH each  target address.
REQ-009 wdata0, wdata1  in  WORD_WIDTH each  write data.
REQ-010 ack0, ack1  out  1 each  one-cycle completion pulse to the owning port.
REQ-011 rdata  out  WORD_WIDTH  read result; valid in the ack cycle, held until the next read completes.
REQ-012 mem_ain, mem_din, mem_read, mem_write, mem_dout  out  1 each  Memory control strobes.
REQ-013 mem_abus  out  ADDRESS_WIDTH  Memory address bus.
REQ-014 dbus_o  out  WORD_WIDTH, dbus_oe  out  1, dbus_i  in  WORD_WIDTH  split data bus; the top level ties these to the tri-state Dbus.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, XFER and ACK; strobes SHALL be decoded from state and latched request only (Moore), with no glitching from req inputs.
REQ-016 IDLE: if either req is high, latch winner index, we, addr and wdata at the edge and go to ADDR; else stay.
REQ-017 Arbitration: a single requester SHALL win; on simultaneous requests the port not granted last SHALL win (round-robin).
REQ-018 ADDR: mem_ain=1 and mem_abus=latched addr; if write, also mem_din=1, dbus_oe=1 and dbus_o=latched wdata; go to XFER.
REQ-019 XFER (read): mem_read=1 and mem_dout=1; rdata SHALL capture dbus_i at the edge; go to ACK.
REQ-020 XFER (write): mem_write=1; go to ACK.
REQ-021 ACK: pulse ack of the winner for exactly one cycle, update the last-granted pointer and return to IDLE.
REQ-022 Latency from request sampled in IDLE to ack high SHALL be 3 cycles; back-to-back transactions SHALL achieve 4 cycles per access.
REQ-023 A req sampled high in IDLE after its own ack SHALL be treated as a new request.
REQ-024 Deassertion of req or changes to addr, we or wdata after latching SHALL NOT affect the transaction in flight, which completes.
REQ-025 Outside the states named above, all strobes, dbus_oe, mem_abus and dbus_o SHALL be 0.
REQ-026 At most one of mem_read or mem_write SHALL be high in any cycle.
REQ-027 dbus_oe and mem_dout SHALL never be high in the same cycle.

Reset
REQ-028 While RSTn=0 (asynchronously): state=IDLE; all strobes, ack0/ack1, dbus_oe, mem_abus, dbus_o and rdata=0; last-granted=port 1, so port 0 wins the first tie.
REQ-029 Reset mid-transaction SHALL abort it with no ack; Memory contents already written SHALL be left as they are.
REQ-030 The first request SHALL be sampled on the first rising edge after RSTn rises.

Structure
REQ-031 State encoding (IDLE=0, ADDR=1, XFER=2, ACK=3) and port index constants SHALL live in shared package mem_ctrl_pkg.
REQ-032 The round-robin grant logic SHALL be sub-module rr_arb2 (inputs req0, req1 and last; output grant index); all else is inline.

Verification
REQ-033 Port 1 write addr=5, wdata=0xA5, then read addr=5 -> ack1 at cycle 3 of each transaction, rdata=0xA5, Memory location 5 = 0xA5.
REQ-034 req0 and req1 raised together after reset (reads, addr 1 and 2) -> port 0 acked first, port 1 acked 4 cycles later.
REQ-035 Both req held continuously for 4 transactions -> grants alternate 0,1,0,1 with no idle cycles between ACK and the next ADDR.
REQ-036 req0 dropped in ADDR of a write (addr=3, wdata=0x3C) -> write still completes, ack0 pulses, Memory location 3 = 0x3C.
REQ-037 RSTn pulsed low during XFER of a write (addr=7, wdata=0xFF) -> strobes immediately 0, no ack, FSM in IDLE, next request serviced normally.
REQ-038 Assertion checks over all tests -> read/write mutual exclusion and no dbus_oe together with mem_dout in any cycle.
